// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: function codes, FSM states and flag layout shared by the sequential ALU slice
package alu_seq_pkg;
  localparam logic [2:0] FN_AND = 3'b000;
  localparam logic [2:0] FN_OR  = 3'b001;
  localparam logic [2:0] FN_ADD = 3'b010;
  localparam logic [2:0] FN_XOR = 3'b011;
  localparam logic [2:0] FN_SHL = 3'b100;
  localparam logic [2:0] FN_SHR = 3'b101;
  localparam logic [2:0] FN_SUB = 3'b110;
  localparam logic [2:0] FN_SLT = 3'b111;
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 0;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_WB} state_t;
  function automatic logic is_shift(input logic [2:0] fn);
    return fn == FN_SHL || fn == FN_SHR;
  endfunction
  function automatic logic [3:0] mk_flags(input logic v, input logic c, input logic z, input logic s);
    logic [3:0] f;
    f = '0;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_S] = s;
    return f;
  endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREG x DATA_W registers, two read ports plus debug port, one write port, r0 tied to zero
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  parameter int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);
  logic [DATA_W-1:0] regs [NREG];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else if (we && wa != '0) regs[wa] <= wd;
  assign rd1      = ra1 == '0 ? '0 : regs[ra1];
  assign rd2      = ra2 == '0 ? '0 : regs[ra2];
  assign dbg_data = dbg_addr == '0 ? '0 : regs[dbg_addr];
endmodule

// File: rtl/alu_regfile_seq.sv
// alu_regfile_seq: handshaked ALU with multi-cycle shifts, write-back into a register file and V/C/Z/S flags
module alu_regfile_seq #(
  parameter int DATA_W  = 16,
  parameter int NREG    = 16,
  parameter int ADDR_W  = $clog2(NREG),
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_fn,
  input  logic [ADDR_W-1:0] op_rd,
  input  logic [ADDR_W-1:0] op_rs1,
  input  logic [ADDR_W-1:0] op_rs2,
  input  logic              op_use_imm,
  input  logic [DATA_W-1:0] op_imm,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        flags,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  import alu_seq_pkg::*;
  localparam int MSB = DATA_W - 1;
  state_t               state;
  logic [2:0]           fn;
  logic [ADDR_W-1:0]    rd;
  logic [DATA_W-1:0]    op1, op2, rs1_data, rs2_data, op2_in, alu_r;
  logic [SHAMT_W-1:0]   cnt, shamt;
  logic                 cbit, alu_c, alu_v, sub_v, add_v;
  logic [DATA_W:0]      sum, dif;
  regfile_2r1w #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) u_rf (
    .clk(clk), .rst(rst), .ra1(op_rs1), .ra2(op_rs2), .dbg_addr(dbg_addr),
    .rd1(rs1_data), .rd2(rs2_data), .dbg_data(dbg_data),
    .we(state == S_WB), .wa(rd), .wd(res_data)
  );
  assign op_ready = state == S_IDLE;
  assign op2_in   = op_use_imm ? op_imm : rs2_data;
  assign shamt    = op2_in[SHAMT_W-1:0];
  assign sum      = {1'b0, op1} + {1'b0, op2};
  assign dif      = {1'b0, op1} - {1'b0, op2};
  assign add_v    = op1[MSB] == op2[MSB] && sum[MSB] != op1[MSB];
  assign sub_v    = op1[MSB] != op2[MSB] && dif[MSB] != op1[MSB];
  // shl/shr only reach EXEC with a zero amount, so they fall through to op1
  assign alu_r = fn == FN_AND ? op1 & op2 :
                 fn == FN_OR  ? op1 | op2 :
                 fn == FN_XOR ? op1 ^ op2 :
                 fn == FN_ADD ? sum[MSB:0] :
                 fn == FN_SUB ? dif[MSB:0] :
                 fn == FN_SLT ? {{(DATA_W-1){1'b0}}, $signed(op1) < $signed(op2)} : op1;
  assign alu_c = fn == FN_ADD ? sum[DATA_W] : (fn == FN_SUB || fn == FN_SLT) ? dif[DATA_W] : 1'b0;
  assign alu_v = fn == FN_ADD ? add_v : (fn == FN_SUB || fn == FN_SLT) ? sub_v : 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= S_IDLE;
      fn        <= '0;
      rd        <= '0;
      op1       <= '0;
      op2       <= '0;
      cnt       <= '0;
      cbit      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      flags     <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: if (op_valid) begin
          fn    <= op_fn;
          rd    <= op_rd;
          op1   <= rs1_data;
          op2   <= op2_in;
          cnt   <= shamt;
          cbit  <= 1'b0;
          state <= is_shift(op_fn) && shamt != '0 ? S_SHIFT : S_EXEC;
        end
        S_EXEC: begin
          res_data  <= alu_r;
          flags     <= mk_flags(alu_v, alu_c, alu_r == '0, alu_r[MSB]);
          res_valid <= 1'b1;
          state     <= S_WB;
        end
        S_SHIFT: if (cnt != '0) begin
          op1  <= fn == FN_SHL ? op1 << 1 : op1 >> 1;
          cbit <= fn == FN_SHL ? op1[MSB] : op1[0];
          cnt  <= cnt - 1'b1;
        end else begin
          res_data  <= op1;
          flags     <= mk_flags(1'b0, cbit, op1 == '0, op1[MSB]);
          res_valid <= 1'b1;
          state     <= S_WB;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_regfile_seq.sv
// tb_alu_regfile_seq: directed literal checks plus randomized ops against a timestamped behavioural model
module tb_alu_regfile_seq;
  logic        clk = 0, rst = 1;
  logic        op_valid = 0, op_use_imm = 0;
  logic [2:0]  op_fn = 0;
  logic [3:0]  op_rd = 0, op_rs1 = 0, op_rs2 = 0, dbg_addr = 0;
  logic [15:0] op_imm = 0;
  wire         op_ready, res_valid;
  wire  [15:0] res_data, dbg_data;
  wire  [3:0]  flags;
  int n_tests = 0, n_fail = 0;
  bit chk_en = 0;

  alu_regfile_seq dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_fn(op_fn),
    .op_rd(op_rd), .op_rs1(op_rs1), .op_rs2(op_rs2), .op_use_imm(op_use_imm), .op_imm(op_imm),
    .res_valid(res_valid), .res_data(res_data), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [15:0] r; logic [3:0] f; logic [4:0] n;} calc_t;

  // flags packed as {V,C,Z,S}; shifts report how many extra cycles they cost
  function automatic calc_t calc(input logic [2:0] fn, input logic [15:0] a, input logic [15:0] b);
    calc_t c;
    int sa = $signed(a), sb = $signed(b), ua = int'(a), ub = int'(b);
    int amt = int'(b[3:0]);
    logic v = 0, cy = 0;
    c.n = 0;
    case (fn)
      3'b000: c.r = a & b;
      3'b001: c.r = a | b;
      3'b011: c.r = a ^ b;
      3'b010: begin c.r = 16'(ua + ub); cy = ua + ub > 65535; v = sa + sb > 32767 || sa + sb < -32768; end
      3'b110: begin c.r = 16'(ua - ub); cy = ua < ub; v = sa - sb > 32767 || sa - sb < -32768; end
      3'b111: begin c.r = sa < sb ? 16'd1 : 16'd0; cy = ua < ub; v = sa - sb > 32767 || sa - sb < -32768; end
      3'b100: begin c.r = a << amt; cy = amt != 0 ? a[16 - amt] : 1'b0; c.n = 5'(amt); end
      default: begin c.r = a >> amt; cy = amt != 0 ? a[amt - 1] : 1'b0; c.n = 5'(amt); end
    endcase
    c.f = {v, cy, c.r == 16'd0, c.r[15]};
    return c;
  endfunction

  logic [15:0] mreg [16];
  logic        mbusy, m_valid;
  logic [15:0] m_res;
  logic [3:0]  m_fl, p_rd;
  calc_t       pend, nxt;
  int          cyc, done_t;

  always_comb nxt = calc(op_fn, mreg[op_rs1], op_use_imm ? op_imm : mreg[op_rs2]);

  always @(posedge clk or posedge rst)
    if (rst) begin
      mbusy <= 0; m_valid <= 0; m_res <= 0; m_fl <= 0; cyc <= 0; done_t <= 0; p_rd <= 0; pend <= '0;
      for (int i = 0; i < 16; i++) mreg[i] <= 0;
    end else begin
      cyc <= cyc + 1;
      m_valid <= mbusy && cyc == done_t;
      if (mbusy && cyc == done_t) begin m_res <= pend.r; m_fl <= pend.f; end
      if (mbusy && cyc == done_t + 1) begin
        if (p_rd != 0) mreg[p_rd] <= pend.r;
        mbusy <= 0;
      end
      if (!mbusy && op_valid) begin
        mbusy <= 1; pend <= nxt; p_rd <= op_rd; done_t <= cyc + 1 + int'(nxt.n);
      end
    end

  always @(negedge clk)
    if (chk_en) begin
      chk("mon_ready", op_ready, !mbusy);
      chk("mon_res_valid", res_valid, m_valid);
      chk("mon_res_data", res_data, m_res);
      chk("mon_flags", flags, m_fl);
      chk("mon_dbg", dbg_data, mreg[dbg_addr]);
    end

  task automatic issue(input logic [2:0] fn, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input bit ui, input logic [15:0] imm, input bit hold);
    int k = 0;
    @(negedge clk);
    op_fn = fn; op_rd = rd; op_rs1 = rs1; op_rs2 = rs2; op_use_imm = ui; op_imm = imm; op_valid = 1;
    while (!op_ready && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) op_valid = 0;
    dbg_addr = 4'($urandom);
  endtask

  task automatic wait_result(output logic [15:0] r, output logic [3:0] f, output int lat);
    lat = 0;
    r = 'x; f = 'x;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (res_valid) break;
    end
    if (!res_valid) chk("result_timeout", 0, 1);
    r = res_data; f = flags;
    @(negedge clk);
    chk("ready_back", op_ready, 1);
  endtask

  task automatic run(input string nm, input logic [2:0] fn, input logic [3:0] rd, input logic [3:0] rs1,
                     input logic [3:0] rs2, input bit ui, input logic [15:0] imm,
                     input logic [15:0] er, input logic [3:0] ef, input int elat);
    logic [15:0] r; logic [3:0] f; int lat;
    issue(fn, rd, rs1, rs2, ui, imm, 0);
    wait_result(r, f, lat);
    chk({nm, "_data"}, r, er);
    chk({nm, "_flags"}, f, ef);
    chk({nm, "_lat"}, lat, elat);
  endtask

  task automatic dbg_all_zero(input string nm);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk); #1 dbg_addr = 4'(a);
      #1 chk(nm, dbg_data, 0);
    end
  endtask

  initial begin
    logic [15:0] r; logic [3:0] f; int lat;
    repeat (3) @(negedge clk);
    #2 rst = 0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_ready", op_ready, 1);
    chk("rst_valid", res_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_data", res_data, 0);
    dbg_all_zero("rst_dbg");

    run("add_7fff", 3'b010, 1, 0, 0, 1, 16'h7FFF, 16'h7FFF, 4'b0000, 2);
    dbg_addr = 1; #1 chk("reg1_7fff", dbg_data, 16'h7FFF);
    run("add_ovf", 3'b010, 2, 1, 0, 1, 16'h0001, 16'h8000, 4'b1001, 2);
    run("sub_zero", 3'b110, 3, 2, 2, 0, 16'h0000, 16'h0000, 4'b0010, 2);
    run("sub_borrow", 3'b110, 4, 0, 0, 1, 16'h0001, 16'hFFFF, 4'b0101, 2);
    run("slt_neg", 3'b111, 5, 2, 0, 1, 16'h0001, 16'h0001, 4'b1000, 2);
    run("or_8001", 3'b001, 1, 2, 0, 1, 16'h0001, 16'h8001, 4'b0001, 2);
    run("shl3", 3'b100, 6, 1, 0, 1, 16'h0003, 16'h0008, 4'b0000, 5);
    run("shr1", 3'b101, 7, 1, 0, 1, 16'h0001, 16'h4000, 4'b0100, 3);
    run("shl16", 3'b100, 8, 1, 0, 1, 16'h0010, 16'h8001, 4'b0001, 2);
    run("xor_r0", 3'b011, 0, 1, 0, 1, 16'hFFFF, 16'h7FFE, 4'b0000, 2);
    dbg_addr = 0; #1 chk("reg0_zero", dbg_data, 0);

    // second op presented while the first is busy must see the first's write-back
    issue(3'b010, 8, 1, 0, 1, 16'h0001, 1);
    issue(3'b010, 9, 8, 0, 1, 16'h0001, 0);
    wait_result(r, f, lat);
    chk("held_chain", r, 16'h8003);

    issue(3'b100, 10, 1, 0, 1, 16'h000A, 0);
    repeat (4) @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
    chk("midrst_ready", op_ready, 1);
    #2 rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", res_valid, 0);
    end
    chk("midrst_flags", flags, 0);
    dbg_all_zero("midrst_dbg");

    for (int i = 0; i < 300; i++) begin
      issue(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
            16'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    @(negedge clk);
    op_valid = 0;
    repeat (30) @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_regfile_seq.md
Name: alu_regfile_seq

Overview:
- Parametrised, clocked successor to the combinational register bank and ALU datapath.
- Accepts one register-to-register or immediate ALU operation at a time over a valid/ready handshake, then executes it.
- Shift operations are multi-cycle.
- Writes the result back to the register file, updates the V/C/Z/S status flags and pulses a result strobe.
- Sits between the control unit / sequencer and memory-side logic; a debug read port lets the bench and top level observe the registers.

Parameters:
- DATA_W, 16, datapath and register width (must be at least 4).
- NREG, 16, number of registers (power of 2, at least 2).
- ADDR_W, $clog2(NREG), register address width.
- SHAMT_W, $clog2(DATA_W), width of the shift amount taken from operand 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- op_valid  in  1  operation request.
- op_ready  out  1  block can accept an operation.
- op_fn  in  3  function code.
- op_rd  in  ADDR_W  destination register.
- op_rs1  in  ADDR_W  source register 1.
- op_rs2  in  ADDR_W  source register 2.
- op_use_imm  in  1  when 1, operand 2 = op_imm instead of reg[op_rs2].
- op_imm  in  DATA_W  immediate operand.
- res_valid  out  1  one-cycle strobe: result written.
- res_data  out  DATA_W  result of the last completed operation.
- flags  out  4  {V,C,Z,S} of the last completed operation.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  combinational reg[dbg_addr]; reads 0 for address 0.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - All registers go to 0 and the FSM goes to IDLE.
  - res_valid=0, res_data=0, flags=0.
  - The in-flight operation is discarded; no write-back occurs.
- Register 0 reads as 0 always. Writes to register 0 are dropped, but res_valid, res_data and flags still update.
- FSM states: IDLE, EXEC, SHIFT, WB.
  - IDLE: op_ready=1. On op_valid, capture fn, rd, operand1=reg[rs1] and operand2 (reg[rs2] or op_imm). Go to EXEC, or to SHIFT if fn is shl/shr and the shift amount is nonzero.
  - EXEC: op_ready=0. Compute the result and flags into holding registers. Go to WB.
  - SHIFT: op_ready=0. Shift the working value by 1 bit per cycle and decrement the count. C records the last bit shifted out. When the count reaches 0, go to WB.
  - WB: commit:
    - write reg[rd] (unless rd=0);
    - drive res_data and flags from the holding registers;
    - assert res_valid for exactly this one cycle;
    - go to IDLE.
- Latency and throughput:
  - Non-shift op accepted on edge E0: res_valid is high in the cycle after E1; the register write lands on E2; op_ready returns in the cycle after E2.
  - Shift by n (n ≥ 1) adds n cycles.
  - Throughput is one operation per 3+n cycles. There are no hazards: the next accepted operation reads post-write values.
- Shift amount: operand2[SHAMT_W-1:0]. Upper bits are ignored. Amount 0 uses the EXEC path (result = operand1, C=0).
- Function codes:
  - 000 AND, 001 OR, 011 XOR: V=C=0.
  - 010 ADD: C = carry out; V = signed overflow.
  - 110 SUB: operand1-operand2. C = borrow (operand1 < operand2 unsigned); V = signed overflow.
  - 111 SLT: result = 1 if operand1 < operand2 signed, else 0. C and V as for SUB.
  - 100 SHL: logical left shift.
  - 101 SHR: logical right shift.
- Z = (result==0) and S = result[DATA_W-1], for all ops.
- Arithmetic wraps modulo 2^DATA_W.
- Outputs: res_data and flags hold their values between operations; they change only in WB or on reset.
- op_valid outside IDLE is ignored. The requester must hold op_valid until it sees op_ready.

Decomposition:
- Shared package alu_seq_pkg:
  - function-code localparams (FN_AND, FN_OR, FN_ADD, FN_XOR, FN_SHL, FN_SHR, FN_SUB, FN_SLT);
  - FSM state encoding;
  - flag bit indices (FLAG_V=3, FLAG_C=2, FLAG_Z=1, FLAG_S=0).
- One sub-module, regfile_2r1w: parametrised NREG x DATA_W register array with 2 combinational read ports plus the debug port, 1 synchronous write port, register 0 hard-wired to 0, and asynchronous clear on rst.

Test Plan:
- Reset then dbg reads of all addresses -> all 0; op_ready=1, res_valid=0, flags=0.
- ADD imm: rs1=0, imm=16'h7FFF, rd=1 -> res_data=7FFF, flags=0000, reg1=7FFF. Then ADD rs1=1, imm=1, rd=2 -> 8000, flags V=1,C=0,Z=0,S=1. Check res_valid 2 cycles after accept and op_ready back on the 3rd.
- SUB r2-r2 -> 0, Z=1, C=0. SUB 0-1 via imm -> FFFF, C=1, S=1. SLT 8000 vs 0001 -> 1.
- SHL reg1=8001 by imm=3 -> 0008, C=0, 3 extra cycles. SHR 8001 by 1 -> 4000, C=1. Shift by 16 (amount field 0) -> unchanged, single-cycle path.
- Write to rd=0 -> res_data valid, dbg reg0 stays 0. op_valid held during EXEC/SHIFT -> not accepted until IDLE.
- Assert rst during SHIFT of a 10-bit shift -> no write, all registers 0, FSM IDLE, res_valid never pulses.
